// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;
  localparam int WIDX_W = WORD_W - 2;

  typedef enum logic [1:0] {SRC_NONE, SRC_IF, SRC_D} src_e;

  typedef struct packed {
    logic              valid;
    src_e              src;
    logic [WIDX_W-1:0] widx;
    logic              we;
    logic [WORD_W-1:0] wdata;
  } acc_stage_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-array signals of the shared memory port.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int MEM_AW = 5
);
  logic              if_req;
  logic [WORD_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [WORD_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [WORD_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [WORD_W-1:0] d_rdata;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_we;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_arb_prio.sv
// Grant selection: data first, except a fetch that has waited STARVE_MAX data grants.
module mem_arb_prio #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_flush,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  logic       fetch_due;

  // Grants are held off while reset is asserted so nothing is accepted then.
  always_comb begin
    fetch_due = if_req && !if_flush && (starve_q == STARVE_LIM);
    d_gnt     = reset && d_req && !fetch_due;
    if_gnt    = reset && if_req && !if_flush && !d_gnt;
    starve_d  = starve_q;
    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory shared by fetch and load/store: grant, access stage, registered response.
// Optional saturating performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_AW     = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_port_arbiter_if.slave       bus,
  output logic [CNT_W-1:0]        perf_if_cnt,
  output logic [CNT_W-1:0]        perf_d_cnt,
  output logic [CNT_W-1:0]        perf_stall_cnt
);

  logic              if_gnt, d_gnt;
  acc_stage_t        acc_q, acc_d;
  logic              if_rvalid_q, d_rvalid_q;
  logic [WORD_W-1:0] if_rdata_q, d_rdata_q;
  logic              fetch_hit, data_hit;

  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk      (clk),
    .reset    (reset),
    .if_req   (bus.if_req),
    .if_flush (bus.if_flush),
    .d_req    (bus.d_req),
    .if_gnt   (if_gnt),
    .d_gnt    (d_gnt)
  );

  // Non-valid cycles keep the previous address/data so the memory pins stay quiet.
  always_comb begin
    acc_d       = acc_q;
    acc_d.valid = if_gnt || d_gnt;
    if (d_gnt) begin
      acc_d.src   = SRC_D;
      acc_d.widx  = bus.d_addr[WORD_W-1:2];
      acc_d.we    = bus.d_we;
      acc_d.wdata = bus.d_wdata;
    end else if (if_gnt) begin
      acc_d.src  = SRC_IF;
      acc_d.widx = bus.if_addr[WORD_W-1:2];
      acc_d.we   = 1'b0;
    end else begin
      acc_d.src = SRC_NONE;
    end
    fetch_hit = acc_q.valid && (acc_q.src == SRC_IF) && !bus.if_flush;
    data_hit  = acc_q.valid && (acc_q.src == SRC_D);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      if_rvalid_q <= fetch_hit;
      d_rvalid_q  <= data_hit;
      if (fetch_hit) begin
        if_rdata_q <= bus.mem_rdata;
      end
      if (data_hit && !acc_q.we) begin
        d_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = if_rvalid_q && !bus.if_flush;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_addr  = acc_q.widx[MEM_AW-1:0];
  assign bus.mem_we    = acc_q.valid && (acc_q.src == SRC_D) && acc_q.we;
  assign bus.mem_wdata = acc_q.wdata;

  // Byte offset and address bits above the array size do not select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.d_addr[1:0], acc_q.widx[WIDX_W-1:MEM_AW]};

`ifdef MEM_ARB_PERF_EN
  logic [CNT_W-1:0] perf_if_q, perf_d_q, perf_stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_if_q    <= '0;
      perf_d_q     <= '0;
      perf_stall_q <= '0;
    end else begin
      if (if_gnt) perf_if_q <= sat_inc(perf_if_q);
      if (d_gnt) perf_d_q <= sat_inc(perf_d_q);
      if (bus.if_req && !if_gnt) perf_stall_q <= sat_inc(perf_stall_q);
    end
  end

  assign perf_if_cnt    = perf_if_q;
  assign perf_d_cnt     = perf_d_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_if_cnt    = '0;
  assign perf_d_cnt     = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants checked per step, accesses and responses via scoreboard queues.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [4:0]  widx;
    bit          we;
    logic [31:0] wdata;
    bit          is_if;
  } acc_t;

  typedef struct {
    int          due;
    bit          we;
    logic [31:0] data;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] perf_if_cnt, perf_d_cnt, perf_stall_cnt;

  int          errors = 0;
  int          checks = 0;
  int          cycle  = 0;
  bit          mon_en = 1'b0;
  int          n_if = 0, n_d = 0, n_stall = 0;
  logic [31:0] if_hold = '0, d_hold = '0;
  logic [31:0] mem       [32];
  logic [31:0] model_mem [32];
  acc_t        memq[$];
  rsp_t        ifq[$];
  rsp_t        dq[$];

  mem_port_arbiter_if #(.MEM_AW(5)) bus ();

  mem_port_arbiter #(.MEM_AW(5), .STARVE_MAX(3)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .bus            (bus.slave),
    .perf_if_cnt    (perf_if_cnt),
    .perf_d_cnt     (perf_d_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE0000 + 32'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic init_model();
    for (int i = 0; i < 32; i++) model_mem[i] = 32'hC0DE0000 + 32'(i);
  endtask

  task automatic chk_perf(input string tag);
    chk({tag, "_perf_if"},    {16'd0, perf_if_cnt},    PERF_ON ? 32'(n_if) : 32'd0);
    chk({tag, "_perf_d"},     {16'd0, perf_d_cnt},     PERF_ON ? 32'(n_d) : 32'd0);
    chk({tag, "_perf_stall"}, {16'd0, perf_stall_cnt}, PERF_ON ? 32'(n_stall) : 32'd0);
  endtask

  // One clock of stimulus; grants are checked and expected traffic is queued.
  task automatic cyc(input bit ireq, input logic [31:0] iaddr, input bit iflush,
                     input bit dreq, input bit dwe, input logic [31:0] daddr,
                     input logic [31:0] dwdata, input bit exp_ig, input bit exp_dg,
                     input string tag);
    acc_t a;
    rsp_t r;
    bus.if_req   = ireq;
    bus.if_addr  = iaddr;
    bus.if_flush = iflush;
    bus.d_req    = dreq;
    bus.d_we     = dwe;
    bus.d_addr   = daddr;
    bus.d_wdata  = dwdata;
    if (iflush) begin
      ifq.delete();
      for (int i = memq.size() - 1; i >= 0; i--) if (memq[i].is_if) memq.delete(i);
    end
    @(negedge clk);
    chk({tag, "_if_gnt"}, {31'd0, bus.if_gnt}, {31'd0, exp_ig});
    chk({tag, "_d_gnt"},  {31'd0, bus.d_gnt},  {31'd0, exp_dg});
    if (exp_dg) begin
      a.due = cycle + 1; a.widx = daddr[6:2]; a.we = dwe; a.wdata = dwdata; a.is_if = 1'b0;
      memq.push_back(a);
      r.due = cycle + 2; r.we = dwe;
      r.data = dwe ? 32'd0 : model_mem[daddr[6:2]];
      if (dwe) model_mem[daddr[6:2]] = dwdata;
      dq.push_back(r);
    end else if (exp_ig) begin
      a.due = cycle + 1; a.widx = iaddr[6:2]; a.we = 1'b0; a.wdata = '0; a.is_if = 1'b1;
      memq.push_back(a);
      r.due = cycle + 2; r.we = 1'b0; r.data = model_mem[iaddr[6:2]];
      ifq.push_back(r);
    end
    n_if    += int'(exp_ig);
    n_d     += int'(exp_dg);
    n_stall += int'(ireq && !exp_ig);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      acc_t a;
      rsp_t r;
      if (memq.size() > 0 && memq[0].due == cycle) begin
        a = memq.pop_front();
        chk("mem_addr", {27'd0, bus.mem_addr}, {27'd0, a.widx});
        chk("mem_we", {31'd0, bus.mem_we}, {31'd0, a.we});
        if (a.we) chk("mem_wdata", bus.mem_wdata, a.wdata);
      end else begin
        chk("mem_we_idle", {31'd0, bus.mem_we}, 32'd0);
      end
      if (ifq.size() > 0 && ifq[0].due == cycle) begin
        r = ifq.pop_front();
        if_hold = r.data;
        chk("if_rvalid", {31'd0, bus.if_rvalid}, 32'd1);
      end else begin
        chk("if_rvalid_idle", {31'd0, bus.if_rvalid}, 32'd0);
      end
      chk("if_rdata", bus.if_rdata, if_hold);
      if (dq.size() > 0 && dq[0].due == cycle) begin
        r = dq.pop_front();
        if (!r.we) d_hold = r.data;
        chk("d_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
      end else begin
        chk("d_rvalid_idle", {31'd0, bus.d_rvalid}, 32'd0);
      end
      chk("d_rdata", bus.d_rdata, d_hold);
    end
  end

  initial begin
    rst_n = 1'b0;
    init_model();
    cyc_drive_reset: begin
      bus.if_req = 1'b1; bus.if_addr = 32'h08; bus.if_flush = 1'b0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10; bus.d_wdata = '0;
    end
    repeat (3) begin
      @(negedge clk);
      chk("rst_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
      chk("rst_d_gnt", {31'd0, bus.d_gnt}, 32'd0);
      chk("rst_rvalids", {30'd0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
      chk("rst_mem", {26'd0, bus.mem_we, bus.mem_addr}, 32'd0);
      chk_perf("rst");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    cyc(1, 32'h08, 0, 0, 0, 0, 0, 1, 0, "t1_fetch");
    idle(3);

    cyc(1, 32'h0C, 0, 1, 0, 32'h13, 0, 0, 1, "t2_both");
    cyc(1, 32'h0C, 0, 0, 0, 0, 0, 1, 0, "t2_fetch");
    idle(3);

    cyc(1, 32'h04, 0, 1, 0, 32'h00, 0, 0, 1, "t3_d0");
    cyc(1, 32'h04, 0, 1, 0, 32'h18, 0, 0, 1, "t3_d1");
    cyc(1, 32'h04, 0, 1, 0, 32'h1C, 0, 0, 1, "t3_d2");
    cyc(1, 32'h04, 0, 1, 0, 32'h20, 0, 1, 0, "t3_starve_if");
    cyc(1, 32'h1000007F, 0, 1, 0, 32'h20, 0, 0, 1, "t3_d_resume");
    cyc(1, 32'h1000007F, 0, 0, 0, 0, 0, 1, 0, "t3_fetch_top");
    idle(3);

    cyc(0, 0, 0, 1, 1, 32'h14, 32'hDEADBEEF, 0, 1, "t4_write");
    cyc(0, 0, 0, 1, 0, 32'h14, 0, 0, 1, "t4_readback");
    idle(3);

    cyc(1, 32'h24, 0, 0, 0, 0, 0, 1, 0, "t5_fetch");
    cyc(0, 0, 1, 1, 0, 32'h08, 0, 0, 1, "t5_flush_d");
    cyc(1, 32'h28, 1, 0, 0, 0, 0, 0, 0, "t5_flush_hold");
    idle(3);
    chk_perf("run");

    cyc(1, 32'h20, 0, 1, 0, 32'h24, 0, 0, 1, "t6_pre");
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.if_flush = 1'b0;
    rst_n = 1'b0;
    mon_en = 1'b0;
    memq.delete(); ifq.delete(); dq.delete();
    if_hold = '0; d_hold = '0;
    n_if = 0; n_d = 0; n_stall = 0;
    init_model();
    #1;
    chk("t6_rst_rvalids", {30'd0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
    chk("t6_rst_mem", {26'd0, bus.mem_we, bus.mem_addr}, 32'd0);
    chk("t6_rst_d_rdata", bus.d_rdata, 32'd0);
    chk_perf("t6_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle(4);
    cyc(1, 32'h0C, 0, 1, 0, 32'h30, 0, 0, 1, "t6_d0");
    cyc(1, 32'h0C, 0, 1, 0, 32'h34, 0, 0, 1, "t6_d1");
    cyc(1, 32'h0C, 0, 1, 0, 32'h38, 0, 0, 1, "t6_d2");
    cyc(1, 32'h0C, 0, 1, 0, 32'h3C, 0, 1, 0, "t6_if");
    idle(4);
    chk_perf("end");
    chk("memq_drained", 32'(memq.size()), 32'd0);
    chk("ifq_drained", 32'(ifq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
